sisc_ctrl_seq: RTL



---
 rtl/sisc_ctrl_pkg.sv | 38 +++
 rtl/sisc_retire_cnt.sv | 23 ++
 rtl/sisc_ctrl_seq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sisc_ctrl_pkg.sv
// Shared definitions for the SISC variable-length control sequencer:
// opcode map, addressing-mode constant, state encoding and ALU control codes.
package sisc_ctrl_pkg;

    localparam int unsigned OPC_NOOP = 32'd0;
    localparam int unsigned OPC_LOD  = 32'd1;
    localparam int unsigned OPC_STR  = 32'd2;
    localparam int unsigned OPC_SWP  = 32'd3;
    localparam int unsigned OPC_BRA  = 32'd4;
    localparam int unsigned OPC_BRR  = 32'd5;
    localparam int unsigned OPC_BNE  = 32'd6;
    localparam int unsigned OPC_BNR  = 32'd7;
    localparam int unsigned OPC_ALU  = 32'd8;
    localparam int unsigned OPC_HLT  = 32'd15;

    localparam int unsigned AM_IMM   = 32'd8;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    // bit0 selects the immediate operand, bit1 suppresses the condition-code update
    localparam logic [1:0] ALU_REG_CC   = 2'b00;
    localparam logic [1:0] ALU_IMM_CC   = 2'b01;
    localparam logic [1:0] ALU_REG_HOLD = 2'b10;
    localparam logic [1:0] ALU_IMM_HOLD = 2'b11;

    function automatic logic [1:0] alu_code(input logic hold_cc, input logic imm);
        return {hold_cc, imm};
    endfunction

endpackage

// File: rtl/sisc_retire_cnt.sv
// Wrapping retired-instruction counter with synchronous clear (priority)
// and an increment enable.
module sisc_retire_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // count register: clear dominates increment
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/sisc_ctrl_seq.sv
// Variable-length SISC control sequencer. Define SISC_CTRL_MEM_WAIT_EN to add
// the mem_rdy port and let the MEM state stall until data memory is done.
module sisc_ctrl_seq
    import sisc_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int COND_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opcode,
    input  logic [COND_W-1:0] mm,
    input  logic [COND_W-1:0] stat,
`ifdef SISC_CTRL_MEM_WAIT_EN
    input  logic              mem_rdy,
`endif
    output logic              pc_rst,
    output logic              pc_write,
    output logic              pc_sel,
    output logic              br_sel,
    output logic              ir_load,
    output logic              rb_sel,
    output logic              mm_sel,
    output logic              dm_we,
    output logic              rf_we,
    output logic              wb_sel,
    output logic [1:0]        alu_op,
    output logic              halted,
    output logic              retire,
    output logic [CNT_W-1:0]  instr_cnt
);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] op_s;
    logic        is_lod_s, is_str_s, is_alu_s, is_hlt_s, is_exec_s;
    logic        br_pos_s, br_neg_s, br_abs_s, taken_s;
    logic        imm_s, mm_zero_s, mem_done_s;

    assign op_s      = 32'(opcode);
    assign imm_s     = (32'(mm) == AM_IMM);
    assign mm_zero_s = (mm == {COND_W{1'b0}});

`ifdef SISC_CTRL_MEM_WAIT_EN
    assign mem_done_s = mem_rdy;
`else
    assign mem_done_s = 1'b1;
`endif

    // opcode classification
    always_comb begin
        is_lod_s  = 1'b0;
        is_str_s  = 1'b0;
        is_alu_s  = 1'b0;
        is_hlt_s  = 1'b0;
        is_exec_s = 1'b0;
        br_pos_s  = 1'b0;
        br_neg_s  = 1'b0;
        br_abs_s  = 1'b0;
        case (op_s)
            OPC_LOD: begin is_lod_s = 1'b1; is_exec_s = 1'b1; end
            OPC_STR: begin is_str_s = 1'b1; is_exec_s = 1'b1; end
            OPC_SWP: is_exec_s = 1'b1;
            OPC_ALU: begin is_alu_s = 1'b1; is_exec_s = 1'b1; end
            OPC_BRA: begin br_pos_s = 1'b1; br_abs_s  = 1'b1; end
            OPC_BRR: br_pos_s = 1'b1;
            OPC_BNE: begin br_neg_s = 1'b1; br_abs_s  = 1'b1; end
            OPC_BNR: br_neg_s = 1'b1;
            OPC_HLT: is_hlt_s = 1'b1;
            default: is_exec_s = 1'b0;
        endcase
    end

    assign taken_s = (br_pos_s & ((mm & stat) != {COND_W{1'b0}})) |
                     (br_neg_s & ((mm & stat) == {COND_W{1'b0}}));

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_START;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_START:     next_state_s = ST_FETCH;
            ST_FETCH:     next_state_s = ST_DECODE;
            ST_DECODE:    next_state_s = is_hlt_s  ? ST_HALT :
                                         is_exec_s ? ST_EXECUTE : ST_FETCH;
            ST_EXECUTE:   next_state_s = is_alu_s ? ST_WRITEBACK :
                                         (is_lod_s | is_str_s) ? ST_MEM : ST_FETCH;
            ST_MEM:       next_state_s = !mem_done_s ? ST_MEM :
                                         is_lod_s ? ST_WRITEBACK : ST_FETCH;
            ST_WRITEBACK: next_state_s = ST_FETCH;
            ST_HALT:      next_state_s = ST_HALT;
            default:      next_state_s = ST_START;
        endcase
    end

    // datapath controls decoded from state, opcode and mode field
    always_comb begin
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        ir_load  = 1'b0;
        rb_sel   = 1'b0;
        mm_sel   = 1'b0;
        dm_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        alu_op   = ALU_REG_HOLD;
        halted   = 1'b0;
        retire   = 1'b0;
        case (state_r)
            ST_START: pc_rst = 1'b1;
            ST_FETCH: begin
                pc_write = 1'b1;
                ir_load  = 1'b1;
            end
            ST_DECODE: begin
                pc_write = taken_s;
                pc_sel   = taken_s;
                br_sel   = br_abs_s;
                rb_sel   = is_str_s;
                retire   = ~is_exec_s & ~is_hlt_s;
            end
            ST_EXECUTE: begin
                alu_op = is_alu_s ? alu_code(1'b0, imm_s) :
                         (is_lod_s | is_str_s) ? ALU_IMM_CC : ALU_REG_HOLD;
                mm_sel = is_lod_s & mm_zero_s;
                rb_sel = is_str_s;
                retire = ~(is_alu_s | is_lod_s | is_str_s);
            end
            ST_MEM: begin
                // stores keep dm_we high for every stalled cycle as well
                alu_op = (is_lod_s | is_str_s) ? ALU_IMM_CC : ALU_REG_HOLD;
                mm_sel = is_lod_s & mm_zero_s;
                rb_sel = is_str_s;
                dm_we  = is_str_s;
                retire = mem_done_s & ~is_lod_s;
            end
            ST_WRITEBACK: begin
                rf_we  = is_alu_s | is_lod_s;
                wb_sel = is_lod_s;
                alu_op = is_alu_s ? alu_code(1'b1, imm_s) :
                         is_lod_s ? ALU_IMM_CC : ALU_REG_HOLD;
                retire = 1'b1;
            end
            ST_HALT: halted = 1'b1;
            default: pc_rst = 1'b0;
        endcase
    end

    sisc_retire_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
        .clk (clk),
        .clr (rst),
        .en  (retire),
        .cnt (instr_cnt)
    );

endmodule
